// File: rtl/sound_pkg.sv
// Shared constants for the sound FIFO and its sample pacer.
// Holds the state encoding, FIFO geometry and the nominal divider.
package sound_pkg;

    localparam int DEPTH  = 32;
    localparam int LEVELW = 6;
    localparam int NOMDIV = 1563;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_RUN     = 2'd2,
        ST_STARVED = 2'd3
    } pacer_state_t;

    // Divider reload value: nominal period plus signed trim, minus one.
    function automatic logic [15:0] period_m1(
        input logic [15:0]       nom,
        input logic signed [7:0] trim
    );
        return nom + {{8{trim[7]}}, trim} - 16'd1;
    endfunction

endpackage

// File: rtl/sound_sample_pacer_if.sv
// Control and status bundle between the pacer and its surroundings.
// The master side drives enable and write pulses; the pacer is the slave.
interface sound_sample_pacer_if import sound_pkg::*; #(
    parameter int LEVELW = sound_pkg::LEVELW
) ();
    logic              IwEnable;
    logic              IwSampleWritten;
    logic              ObNextAudioSamples;
    logic [LEVELW-1:0] ObLevel;
    logic [7:0]        ObTrim;
    logic [1:0]        ObState;
    logic [7:0]        ObUnderrunCount;
    logic [7:0]        ObOverrunCount;

    modport master (
        output IwEnable, IwSampleWritten,
        input  ObNextAudioSamples, ObLevel, ObTrim, ObState,
        input  ObUnderrunCount, ObOverrunCount
    );

    modport slave (
        input  IwEnable, IwSampleWritten,
        output ObNextAudioSamples, ObLevel, ObTrim, ObState,
        output ObUnderrunCount, ObOverrunCount
    );
endinterface

// File: rtl/sound_sample_pacer_sat_counter8.sv
// 8-bit event counter that sticks at 255.
// Used for underrun and overrun statistics.
module sat_counter8 import sound_pkg::*; (
    input  logic       IwClk,
    input  logic       IwReset,
    input  logic       inc,
    output logic [7:0] count
);
    logic [7:0] count_q, count_d;

    // Next count: step on an event unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge IwClk or posedge IwReset) begin
        if (IwReset) count_q <= 8'd0;
        else         count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/sound_sample_pacer.sv
// Sample pacer: strobes FIFO advances at the audio rate and trims
// the period so the FIFO hovers near half full.
module sound_sample_pacer import sound_pkg::*; #(
    parameter int DEPTH     = sound_pkg::DEPTH,
    parameter int LEVELW    = sound_pkg::LEVELW,
    parameter int NOMDIV    = sound_pkg::NOMDIV,
    parameter int TRIMMAX   = 64,
    parameter int PRIMEMARK = 16,
    parameter int LOWMARK   = 12,
    parameter int HIGHMARK  = 20
) (
    input logic IwClk,
    input logic IwReset,
    sound_sample_pacer_if.slave bus
);
    localparam logic [LEVELW-1:0] FULL   = LEVELW'(DEPTH - 1);
    localparam logic [LEVELW-1:0] LVL2   = LEVELW'(2);
    localparam logic [LEVELW-1:0] PRIMEL = LEVELW'(PRIMEMARK);
    localparam logic [LEVELW-1:0] LOWL   = LEVELW'(LOWMARK);
    localparam logic [LEVELW-1:0] HIGHL  = LEVELW'(HIGHMARK);
    localparam logic [LEVELW-1:0] ONE    = LEVELW'(1);
    localparam logic signed [7:0] TMAX   = 8'(TRIMMAX);
    localparam logic signed [7:0] TMIN   = 8'(-TRIMMAX);
    localparam logic [15:0]       NOM16  = 16'(NOMDIV);
    localparam logic [15:0]       HOLD   = 16'(NOMDIV - 1);

    pacer_state_t      state_q, state_d;
    logic [15:0]       div_q, div_d;
    logic [LEVELW-1:0] level_q, level_d;
    logic signed [7:0] trim_q, trim_d;
    logic              strobe_q, strobe_d;
    logic              wacc, drop, tick, starve, go_run;

    // Event decode: accepted/dropped writes, divider tick, advance decision.
    always_comb begin
        wacc     = bus.IwSampleWritten && (level_q != FULL);
        drop     = bus.IwSampleWritten && !wacc;
        tick     = bus.IwEnable && (state_q == ST_RUN) && (div_q == 16'd0);
        strobe_d = tick && (level_q >= LVL2);
        starve   = tick && !strobe_d;
        go_run   = bus.IwEnable && (state_q == ST_PRIME)
                   && (level_q >= PRIMEL);
    end

    // Occupancy follows accepted writes and issued advance strobes.
    always_comb begin
        level_d = level_q;
        if (wacc && !strobe_q)      level_d = level_q + ONE;
        else if (!wacc && strobe_q) level_d = level_q - ONE;
    end

    // Trim nudges the period toward half full on every issued strobe.
    always_comb begin
        trim_d = trim_q;
        if (strobe_d) begin
            if ((level_q > HIGHL) && (trim_q > TMIN))
                trim_d = trim_q - 8'sd1;
            else if ((level_q < LOWL) && (trim_q < TMAX))
                trim_d = trim_q + 8'sd1;
        end
    end

    // Divider counts down in RUN; it is loaded with the trimmed period on
    // RUN entry so the first tick obeys the current trim.
    always_comb begin
        div_d = HOLD;
        if (bus.IwEnable && (state_q == ST_RUN)) begin
            div_d = (div_q == 16'd0) ? period_m1(NOM16, trim_q)
                                     : div_q - 16'd1;
        end else if (go_run) begin
            div_d = period_m1(NOM16, trim_q);
        end
    end

    // Next state; dropping enable always wins.
    always_comb begin
        state_d = state_q;
        if (!bus.IwEnable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_PRIME;
                ST_PRIME:   if (go_run) state_d = ST_RUN;
                ST_RUN:     if (starve) state_d = ST_STARVED;
                ST_STARVED: state_d = ST_PRIME;
            endcase
        end
    end

    // Pacer state registers; the strobe is registered so it cannot glitch.
    always_ff @(posedge IwClk or posedge IwReset) begin
        if (IwReset) begin
            state_q  <= ST_IDLE;
            div_q    <= 16'd0;
            level_q  <= '0;
            trim_q   <= 8'sd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            level_q  <= level_d;
            trim_q   <= trim_d;
            strobe_q <= strobe_d;
        end
    end

    sat_counter8 u_underrun (
        .IwClk   (IwClk),
        .IwReset (IwReset),
        .inc     (starve),
        .count   (bus.ObUnderrunCount)
    );

    sat_counter8 u_overrun (
        .IwClk   (IwClk),
        .IwReset (IwReset),
        .inc     (drop),
        .count   (bus.ObOverrunCount)
    );

    assign bus.ObNextAudioSamples = strobe_q;
    assign bus.ObLevel            = level_q;
    assign bus.ObTrim             = trim_q;
    assign bus.ObState            = state_q;
endmodule

// File: tb/tb_sound_sample_pacer.sv
// Randomized bench for sound_sample_pacer with a queue scoreboard
// fed by an event/time-based reference model.
module tb_sound_sample_pacer;
    localparam int N  = 100;
    localparam int TM = 64;
    localparam int PM = 16;
    localparam int LM = 12;
    localparam int HM = 20;
    localparam int D  = 32;
    localparam int LW = 6;

    logic IwClk = 1'b0;
    logic IwReset;

    always #5 IwClk = ~IwClk;

    sound_sample_pacer_if #(.LEVELW(LW)) bus ();

    sound_sample_pacer #(
        .DEPTH(D), .LEVELW(LW), .NOMDIV(N), .TRIMMAX(TM),
        .PRIMEMARK(PM), .LOWMARK(LM), .HIGHMARK(HM)
    ) dut (
        .IwClk   (IwClk),
        .IwReset (IwReset),
        .bus     (bus)
    );

    typedef struct {
        bit stb;
        int level;
        int trim;
        int st;
        int unr;
        int ovr;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: mode, occupancy, trim, counters and the absolute
    // cycle at which the next pacing tick is due.
    int m_st, m_lvl, m_trim, m_unr, m_ovr, m_tick_at, cyc;
    bit m_stb;

    task automatic model_clear();
        m_st = 0; m_lvl = 0; m_trim = 0;
        m_unr = 0; m_ovr = 0; m_stb = 0; m_tick_at = 0;
    endtask

    task automatic model_cycle(input bit en, input bit wr);
        bit acc, tk, ns;
        int nl, nt, nst;
        acc = wr && (m_lvl != D - 1);
        nl  = m_lvl + int'(acc) - int'(m_stb);
        if (wr && !acc && m_ovr < 255) m_ovr++;
        tk  = en && (m_st == 2) && (cyc == m_tick_at);
        ns  = tk && (m_lvl >= 2);
        nt  = m_trim;
        if (ns) begin
            if (m_lvl > HM && m_trim > -TM)      nt = m_trim - 1;
            else if (m_lvl < LM && m_trim < TM)  nt = m_trim + 1;
        end
        nst = m_st;
        if (!en) nst = 0;
        else begin
            case (m_st)
                0: nst = 1;
                1: if (m_lvl >= PM) begin
                       nst = 2;
                       m_tick_at = cyc + N + m_trim;
                   end
                2: begin
                       if (ns) m_tick_at = cyc + N + m_trim;
                       if (tk && !ns) begin
                           nst = 3;
                           if (m_unr < 255) m_unr++;
                       end
                   end
                default: nst = 1;
            endcase
        end
        m_lvl = nl; m_trim = nt; m_st = nst; m_stb = ns;
    endtask

    task automatic step(input bit en, input bit wr);
        exp_t e;
        bus.IwEnable        = en;
        bus.IwSampleWritten = wr;
        if (IwReset) model_clear();
        else         model_cycle(en, wr);
        @(posedge IwClk);
        #1;
        e.stb = m_stb; e.level = m_lvl; e.trim = m_trim;
        e.st = m_st; e.unr = m_unr; e.ovr = m_ovr;
        q.push_back(e);
        cyc++;
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({bus.ObNextAudioSamples, bus.ObLevel, bus.ObTrim, bus.ObState,
             bus.ObUnderrunCount, bus.ObOverrunCount} !== '0) begin
            n_bad++;
            $display("FAIL %s: stb=%0b lvl=%0d trim=%0d st=%0d unr=%0d ovr=%0d, want all 0",
                     name, bus.ObNextAudioSamples, bus.ObLevel, bus.ObTrim,
                     bus.ObState, bus.ObUnderrunCount, bus.ObOverrunCount);
        end
    endtask

    // Monitor: every presented output cycle is checked against the queue.
    initial begin
        forever begin
            @(negedge IwClk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                if ({bus.ObNextAudioSamples, bus.ObLevel, bus.ObTrim,
                     bus.ObState, bus.ObUnderrunCount, bus.ObOverrunCount}
                    !== {e.stb, 6'(e.level), 8'(e.trim), 2'(e.st),
                         8'(e.unr), 8'(e.ovr)}) begin
                    n_bad++;
                    if (n_bad <= 20)
                        $display("FAIL cycle %0t: got stb=%0b lvl=%0d trim=%0d st=%0d unr=%0d ovr=%0d want stb=%0b lvl=%0d trim=%0d st=%0d unr=%0d ovr=%0d",
                                 $time, bus.ObNextAudioSamples, bus.ObLevel,
                                 $signed(bus.ObTrim), bus.ObState,
                                 bus.ObUnderrunCount, bus.ObOverrunCount,
                                 e.stb, e.level, e.trim, e.st, e.unr, e.ovr);
                end
            end
        end
    end

    initial begin
        bus.IwEnable        = 1'b0;
        bus.IwSampleWritten = 1'b0;
        IwReset = 1'b0;
        cyc = 0;
        model_clear();
        #1 IwReset = 1'b1;
        #1 check_zero("reset_state");
        repeat (3) step(1'b0, 1'b0);
        IwReset = 1'b0;

        // Prime with 16 writes spaced 10 cycles apart, then run.
        repeat (16) begin
            step(1'b1, 1'b1);
            repeat (9) step(1'b1, 1'b0);
        end
        repeat (150) step(1'b1, 1'b0);

        // Writes outpace strobes: trim walks down to its limit.
        repeat (6000) step(1'b1, 1'($urandom_range(0, 3) != 0));

        // Asynchronous reset while running.
        @(negedge IwClk);
        #1 IwReset = 1'b1;
        #1 check_zero("reset_mid_run");
        model_clear();
        repeat (2) step(1'b0, 1'b0);
        IwReset = 1'b0;

        // Overrun: 40 writes with the pacer disabled.
        repeat (40) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        repeat (4) step(1'b0, 1'b0);

        // Run then starve: no further writes.
        repeat (3000) step(1'b1, 1'b0);

        // Mixed traffic with occasional disable.
        repeat (4000)
            step(1'($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 89) == 0));
        repeat (2000) step(1'b1, 1'($urandom_range(0, 1)));

        @(negedge IwClk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sound_sample_pacer.md
# sound_sample_pacer

Paces sample consumption from the I2S-fed sound FIFO. It generates the one-cycle next-sample strobe at a nominal audio rate derived from `IwClk`, and tracks FIFO occupancy by counting write and advance events. It trims the strobe period so the FIFO stays near half-full, which absorbs drift between the Pi's I2S clock and the local clock. It sits between the sound FIFO and the audio output logic, which samples the FIFO output on each strobe.

## Interface
- `DEPTH`, 32: FIFO entries. Usable occupancy is `DEPTH-1`.
- `LEVELW`, 6: occupancy counter width. Must hold `DEPTH-1`.
- `NOMDIV`, 1563: nominal strobe period in `IwClk` cycles (50 MHz / 32 kHz). Must be ≥ 2 + `TRIMMAX`.
- `TRIMMAX`, 64: maximum trim magnitude in cycles.
- `PRIMEMARK`, 16: occupancy required before strobing starts.
- `LOWMARK`, 12 / `HIGHMARK`, 20: trim thresholds.
- `IwClk` in 1: system clock.
- `IwReset` in 1: reset, asynchronous, active-high.
- `IwEnable` in 1: run request. Low means return to IDLE.
- `IwSampleWritten` in 1: one-cycle pulse when the I2S side presents a sample to the FIFO (the FIFO's internal write strobe).
- `ObNextAudioSamples` out 1: one-cycle advance strobe to the FIFO.
- `ObLevel` out `LEVELW`: tracked occupancy.
- `ObTrim` out 8: signed current trim, two's complement.
- `ObState` out 2: IDLE=0, PRIME=1, RUN=2, STARVED=3.
- `ObUnderrunCount` out 8: saturating count of starvation events.
- `ObOverrunCount` out 8: saturating count of dropped writes.

## Operation
- Reset value of every output is 0. State is IDLE, divider is 0, trim is 0.
- Write acceptance: `wacc = IwSampleWritten && (ObLevel != DEPTH-1)`. A write at full occupancy is dropped: `ObLevel` is unchanged and `ObOverrunCount` increments, saturating at 255.
- Advance rule: a strobe is issued only if `ObLevel >= 2`. The FIFO refuses to advance onto its write pointer.
- Level update each cycle: `+wacc`, `-strobe`. When both occur in the same cycle, the level is unchanged.
- Divider counts down from `NOMDIV + trim - 1` to 0. Reaching 0 is a tick, and the divider reloads with the current trim. The divider runs only in RUN; in other states it is held at `NOMDIV - 1`.
- State transitions:
  - IDLE → PRIME when `IwEnable` is high.
  - PRIME → RUN when `ObLevel >= PRIMEMARK`.
  - RUN, on a tick: if `ObLevel >= 2`, issue the strobe. Otherwise go to STARVED and increment `ObUnderrunCount` (saturating).
  - STARVED → PRIME on the next cycle. Trim is kept.
  - Any state → IDLE when `IwEnable` is low. The level is still tracked in IDLE; trim and counters are held.
- Trim, evaluated on each issued strobe using the pre-decrement level:
  - `ObLevel > HIGHMARK`: trim decrements (faster strobes).
  - `ObLevel < LOWMARK`: trim increments (slower strobes).
  - Otherwise trim is unchanged.
  - Trim saturates at ±`TRIMMAX`.
- Period arithmetic is done at 16 bits, sign-extending trim.

## Timing
- The strobe is registered. It is high for exactly 1 cycle, in the cycle after the tick.
- Minimum strobe spacing is `NOMDIV - TRIMMAX` cycles, which is ≥ 2, so the FIFO's edge detector sees every strobe.
- `ObLevel` reflects an event in the cycle after the event occurs.
- The PRIME → RUN check uses the registered level. The first tick comes `NOMDIV + trim` cycles after entering RUN.
- Asserting `IwReset` mid-operation clears everything immediately, with no strobe glitch. Because the FIFO itself is not reset, system reset must hold both blocks together.

## Structure
- Shared package `sound_pkg`:
  - State encoding constants.
  - `DEPTH` and `LEVELW`, shared with the sound FIFO.
  - `NOMDIV` per system clock.
- Natural sub-module: `sat_counter8`, an 8-bit saturating event counter instantiated twice (underrun, overrun).

## Test plan
- **Prime/start.** Set `NOMDIV=100`. Enable, then write 16 samples spaced 10 cycles apart.
  - PRIME is held until level 16, then RUN.
  - First strobe comes 100 cycles later; level goes to 15.
- **Trim.** Keep writes faster than strobes so the level exceeds 20.
  - Trim steps -1 per strobe down to -64, then holds.
  - Strobe spacing shrinks to 36 cycles.
- **Starvation.** Stop writes in RUN.
  - Strobes continue until level 1.
  - The next tick enters STARVED, `ObUnderrunCount=1`, then PRIME.
  - No strobe is issued at level 1.
- **Overrun.** Write 40 samples with no strobes (enable low).
  - Level saturates at 31.
  - `ObOverrunCount=9`.
- **Simultaneous events.** Assert a write in the same cycle as a strobe at level 16.
  - Level stays 16.
- **Reset mid-RUN.** Assert `IwReset` in RUN.
  - All outputs read 0 in the same cycle.
  - No strobe is issued after release until the prime condition is met again.
